sha2_hcu: RTL and testbench

- Hash compression unit; sits directly downstream of the W(t) message-schedule stage.
- Consumes the W(t) stream one word per round and runs the SHA-2 compression rounds: 64 rounds for SHA-224/256, 80 rounds for SHA-384/512.
- Accumulates the intermediate hash H0..H7 across blocks. Emits the final digest on an AXI-Stream master once the last block of a message completes.

---
 rtl/sha2_pkg.sv | 85 ++++++++
 rtl/sha2_k_rom.sv | 13 +
 rtl/sha2_hcu.sv | 146 ++++++++++++++
 tb/tb_sha2_hcu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// Shared SHA-2 encodings, initial hash values, round constants and round helper functions.
package sha2_pkg;

  typedef enum logic [1:0] {
    SHA224 = 2'b00,
    SHA256 = 2'b01,
    SHA384 = 2'b10,
    SHA512 = 2'b11
  } sha_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ADD   = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam logic [6:0] STEPS_32 = 7'd64;
  localparam logic [6:0] STEPS_64 = 7'd80;

  localparam int S0_32 [3] = '{2, 13, 22};
  localparam int S1_32 [3] = '{6, 11, 25};
  localparam int S0_64 [3] = '{28, 34, 39};
  localparam int S1_64 [3] = '{14, 18, 41};

  // SHA-512 constants; the SHA-256 constants are exactly their upper 32 bits.
  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  // H0 in the top 64 bits; 32-bit family words are zero-extended.
  function automatic logic [511:0] iv_of(input sha_type_e ty);
    case (ty)
      SHA224: return {32'd0, 32'hc1059ed8, 32'd0, 32'h367cd507, 32'd0, 32'h3070dd17, 32'd0, 32'hf70e5939,
                      32'd0, 32'hffc00b31, 32'd0, 32'h68581511, 32'd0, 32'h64f98fa7, 32'd0, 32'hbefa4fa4};
      SHA256: return {32'd0, 32'h6a09e667, 32'd0, 32'hbb67ae85, 32'd0, 32'h3c6ef372, 32'd0, 32'ha54ff53a,
                      32'd0, 32'h510e527f, 32'd0, 32'h9b05688c, 32'd0, 32'h1f83d9ab, 32'd0, 32'h5be0cd19};
      SHA384: return {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
                      64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
      default: return {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                       64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    endcase
  endfunction

  function automatic logic [63:0] wmask(input logic [63:0] x, input logic f64);
    return f64 ? x : {32'd0, x[31:0]};
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input logic f64);
    logic [31:0] lo;
    lo = x[31:0];
    if (f64) return (x >> n) | (x << (64 - n));
    return {32'd0, (lo >> n) | (lo << (32 - n))};
  endfunction

  function automatic logic [63:0] bsig0(input logic [63:0] x, input logic f64);
    if (f64) return rotr(x, S0_64[0], 1'b1) ^ rotr(x, S0_64[1], 1'b1) ^ rotr(x, S0_64[2], 1'b1);
    return rotr(x, S0_32[0], 1'b0) ^ rotr(x, S0_32[1], 1'b0) ^ rotr(x, S0_32[2], 1'b0);
  endfunction

  function automatic logic [63:0] bsig1(input logic [63:0] x, input logic f64);
    if (f64) return rotr(x, S1_64[0], 1'b1) ^ rotr(x, S1_64[1], 1'b1) ^ rotr(x, S1_64[2], 1'b1);
    return rotr(x, S1_32[0], 1'b0) ^ rotr(x, S1_32[1], 1'b0) ^ rotr(x, S1_32[2], 1'b0);
  endfunction

endpackage

// File: rtl/sha2_k_rom.sv
// Combinational K(t) lookup; 32-bit family returns the SHA-256 constant in [31:0].
module sha2_k_rom import sha2_pkg::*; (
  input  logic [6:0]  idx,
  input  logic        fam64,
  output logic [63:0] k
);
  logic [63:0] k64;

  always_comb begin
    k64 = (idx < STEPS_64) ? K512[idx] : 64'd0;
    k   = fam64 ? k64 : {32'd0, k64[63:32]};
  end
endmodule

// File: rtl/sha2_hcu.sv
// SHA-2 compression unit: one round per accepted W beat, digest valid 2 cycles after the final beat.
// Input stalls hold all state; the digest is held on m_axis until accepted.
module sha2_hcu import sha2_pkg::*; #(
  parameter int S_AXIS_DATA_WIDTH = 64,
  parameter int M_AXIS_DATA_WIDTH = 512
) (
  input  logic                         axi_aclk,
  input  logic                         axi_resetn,
  input  logic [1:0]                   sha_type,
  input  logic                         en,
  output logic                         busy,
  input  logic [S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [M_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast
);
  state_e           state_q, state_d;
  sha_type_e        type_q, type_d;
  logic [6:0]       t_q, t_d;
  logic             last_q, last_d;
  logic [7:0][63:0] wv_q, wv_d;
  logic [7:0][63:0] h_q, h_d;

  logic             f64;
  logic [63:0]      k_t, w_t, t1, t2, ch, maj;
  logic [7:0][63:0] rnd, iv_w;
  logic [511:0]     iv_flat, d512;
  logic [255:0]     d256;
  logic [M_AXIS_DATA_WIDTH-1:0] digest;

  assign f64 = type_q[1];

  sha2_k_rom u_k_rom (
    .idx   (t_q),
    .fam64 (f64),
    .k     (k_t)
  );

  // Index 0 holds a, index 7 holds h.
  always_comb begin
    w_t    = wmask(s_axis_tdata[63:0], f64);
    ch     = (wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]);
    maj    = (wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]);
    t1     = wmask(wv_q[7] + bsig1(wv_q[4], f64) + ch + k_t + w_t, f64);
    t2     = wmask(bsig0(wv_q[0], f64) + maj, f64);
    rnd[7] = wv_q[6];
    rnd[6] = wv_q[5];
    rnd[5] = wv_q[4];
    rnd[4] = wmask(wv_q[3] + t1, f64);
    rnd[3] = wv_q[2];
    rnd[2] = wv_q[1];
    rnd[1] = wv_q[0];
    rnd[0] = wmask(t1 + t2, f64);
  end

  always_comb begin
    iv_flat = iv_of(sha_type_e'(sha_type));
    for (int i = 0; i < 8; i++) iv_w[i] = iv_flat[511-64*i -: 64];
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    t_d     = t_q;
    last_d  = last_q;
    wv_d    = wv_q;
    h_d     = h_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          type_d  = sha_type_e'(sha_type);
          h_d     = iv_w;
          wv_d    = iv_w;
          t_d     = '0;
          last_d  = 1'b0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (s_axis_tvalid) begin
          wv_d = rnd;
          t_d  = t_q + 7'd1;
          if (t_q == (f64 ? STEPS_64 : STEPS_32) - 7'd1) begin
            last_d  = s_axis_tlast;
            state_d = ST_ADD;
          end
        end
      end
      ST_ADD: begin
        for (int i = 0; i < 8; i++) h_d[i] = wmask(h_q[i] + wv_q[i], f64);
        wv_d    = h_d;
        t_d     = '0;
        state_d = last_q ? ST_OUT : ST_ROUND;
      end
      ST_OUT: begin
        if (m_axis_tready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // H0 lands in the most-significant used bits; truncated variants drop trailing words.
  always_comb begin
    d256 = '0;
    d512 = '0;
    for (int i = 0; i < 8; i++) begin
      d256[255-32*i -: 32] = h_q[i][31:0];
      d512[511-64*i -: 64] = h_q[i];
    end
    digest = '0;
    case (type_q)
      SHA224:  digest[223:0] = d256[255:32];
      SHA256:  digest[255:0] = d256;
      SHA384:  digest[383:0] = d512[511:128];
      default: digest[511:0] = d512;
    endcase
  end

  assign busy          = (state_q != ST_IDLE);
  assign s_axis_tready = (state_q == ST_ROUND);
  assign m_axis_tvalid = (state_q == ST_OUT);
  assign m_axis_tlast  = m_axis_tvalid;
  assign m_axis_tdata  = m_axis_tvalid ? digest : '0;

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q <= ST_IDLE;
      type_q  <= SHA224;
      t_q     <= '0;
      last_q  <= 1'b0;
      wv_q    <= '0;
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      t_q     <= t_d;
      last_q  <= last_d;
      wv_q    <= wv_d;
      h_q     <= h_d;
    end
  end
endmodule

// File: tb/tb_sha2_hcu.sv
// Known-answer digests plus random messages, stalls and backpressure checked against a message-level SHA-2 model.
module tb_sha2_hcu;
  import sha2_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   sha_type;
  logic         en;
  logic         busy;
  logic [63:0]  s_tdata;
  logic         s_tvalid, s_tready, s_tlast;
  logic [511:0] m_tdata;
  logic         m_tvalid, m_tready, m_tlast;

  int n_cmp = 0;
  int n_bad = 0;
  int dig_cnt = 0;
  int runs = 0;

  byte unsigned msg_q[$];
  logic [63:0]  wq[$];
  logic [511:0] mdl_dig;

  always #5 clk = ~clk;

  sha2_hcu dut (
    .axi_aclk      (clk),
    .axi_resetn    (rst_n),
    .sha_type      (sha_type),
    .en            (en),
    .busy          (busy),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
  );

  always @(posedge clk) if (rst_n && m_tvalid && m_tready) dig_cnt <= dig_cnt + 1;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] msk(input logic [63:0] x, input bit f64);
    return f64 ? x : (x & 64'hffff_ffff);
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int n, input bit f64);
    if (f64) return (x >> n) | (x << (64 - n));
    return ((x & 64'hffff_ffff) >> n) | ((x << (32 - n)) & 64'hffff_ffff);
  endfunction

  task automatic msg_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  task automatic msg_rand(input int n);
    msg_q.delete();
    repeat (n) msg_q.push_back(8'($urandom));
  endtask

  // Pads msg_q, expands the schedule, compresses every block; fills wq and mdl_dig.
  task automatic build(input logic [1:0] ty);
    bit f64;
    int bs, nr, wb, nwords;
    byte unsigned p[$];
    logic [63:0] H[8], W[80], v[8];
    logic [63:0] t1, t2, kk, s0, s1, ch, mj;
    logic [511:0] ivf;
    longint unsigned nbits;
    f64 = ty[1];
    bs = f64 ? 128 : 64;
    nr = f64 ? 80 : 64;
    wb = f64 ? 8 : 4;
    nbits = 64'(msg_q.size()) * 8;
    p = msg_q;
    p.push_back(8'h80);
    while ((p.size() % bs) != (bs - 2 * wb)) p.push_back(8'h00);
    for (int i = 2 * wb - 1; i >= 0; i--) p.push_back(i < 8 ? 8'(nbits >> (8 * i)) : 8'h00);
    ivf = iv_of(sha_type_e'(ty));
    for (int i = 0; i < 8; i++) H[i] = ivf[511-64*i -: 64];
    wq.delete();
    for (int b = 0; b < p.size() / bs; b++) begin
      for (int j = 0; j < 16; j++) begin
        W[j] = 64'd0;
        for (int k = 0; k < wb; k++) W[j] = (W[j] << 8) | 64'(p[b*bs + j*wb + k]);
      end
      for (int j = 16; j < nr; j++) begin
        if (f64) begin
          s0 = ror(W[j-15], 1, 1) ^ ror(W[j-15], 8, 1) ^ (W[j-15] >> 7);
          s1 = ror(W[j-2], 19, 1) ^ ror(W[j-2], 61, 1) ^ (W[j-2] >> 6);
        end else begin
          s0 = ror(W[j-15], 7, 0) ^ ror(W[j-15], 18, 0) ^ (W[j-15] >> 3);
          s1 = ror(W[j-2], 17, 0) ^ ror(W[j-2], 19, 0) ^ (W[j-2] >> 10);
        end
        W[j] = msk(s1 + W[j-7] + s0 + W[j-16], f64);
      end
      v = H;
      for (int j = 0; j < nr; j++) begin
        kk = f64 ? K512[j] : (K512[j] >> 32);
        if (f64) begin
          s1 = ror(v[4], 14, 1) ^ ror(v[4], 18, 1) ^ ror(v[4], 41, 1);
          s0 = ror(v[0], 28, 1) ^ ror(v[0], 34, 1) ^ ror(v[0], 39, 1);
        end else begin
          s1 = ror(v[4], 6, 0) ^ ror(v[4], 11, 0) ^ ror(v[4], 25, 0);
          s0 = ror(v[0], 2, 0) ^ ror(v[0], 13, 0) ^ ror(v[0], 22, 0);
        end
        ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
        mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
        t1 = msk(v[7] + s1 + ch + kk + W[j], f64);
        t2 = msk(s0 + mj, f64);
        v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = msk(v[3] + t1, f64);
        v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = msk(t1 + t2, f64);
        wq.push_back(W[j]);
      end
      for (int i = 0; i < 8; i++) H[i] = msk(H[i] + v[i], f64);
    end
    nwords = (ty == 2'b00) ? 7 : (ty == 2'b10) ? 6 : 8;
    mdl_dig = '0;
    for (int i = 0; i < nwords; i++)
      mdl_dig = f64 ? ((mdl_dig << 64) | 512'(H[i])) : ((mdl_dig << 32) | 512'(H[i]));
  endtask

  // Asserts reset from the current negedge; outputs must read zero while it is held.
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    m_tready = 1'b0;
    repeat (cycles) begin
      en = 1'($urandom);
      s_tvalid = 1'($urandom);
      @(negedge clk);
      check("rst_ctl", {busy, s_tready, m_tvalid, m_tlast}, 4'b0000);
      check("rst_tdata", m_tdata, 512'd0);
    end
    rst_n = 1'b1;
    en = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic run(input logic [1:0] ty, input int gap, input int hold, input bit en_hold,
                     input logic [511:0] exp, input string tag);
    int idx, guard, nb, nr;
    bit pend, stalled, rdy;
    idx = 0; guard = 0; pend = 0; stalled = 0;
    nb = wq.size();
    nr = ty[1] ? 80 : 64;
    runs++;
    @(negedge clk);
    sha_type = ty;
    en = 1'b1;
    m_tready = 1'b0;
    @(negedge clk);
    en = en_hold;
    check({tag, "_start"}, {busy, s_tready}, 2'b11);
    while (idx < nb && guard < 20000) begin
      guard++;
      if (!pend) begin
        if (gap > 0 && (idx % nr) == nr - 1 && !stalled) begin
          s_tvalid = 1'b0;
          stalled = 1;
        end else if ($urandom_range(99) < gap) begin
          s_tvalid = 1'b0;
        end else begin
          s_tvalid = 1'b1;
          s_tdata = ty[1] ? wq[idx] : {$urandom(), wq[idx][31:0]};
          s_tlast = (idx == nb - 1) || ((idx % nr) != nr - 1 && $urandom_range(7) == 0);
        end
      end
      rdy = s_tready;
      @(negedge clk);
      if (s_tvalid && rdy) begin
        idx++;
        stalled = 0;
        pend = 0;
      end else begin
        pend = s_tvalid;
      end
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    if (idx < nb) begin
      check({tag, "_timeout"}, 512'(idx), 512'(nb));
      do_reset(2);
      return;
    end
    check({tag, "_add_cycle"}, {m_tvalid, busy}, 2'b01);
    @(negedge clk);
    check({tag, "_latency"}, m_tvalid, 1'b1);
    repeat (hold) begin
      check({tag, "_hold"}, m_tdata, exp);
      @(negedge clk);
    end
    check({tag, "_digest"}, m_tdata, exp);
    check({tag, "_vld_last"}, {m_tvalid, m_tlast}, 2'b11);
    m_tready = 1'b1;
    @(negedge clk);
    m_tready = 1'b0;
    en = 1'b0;
    check({tag, "_done"}, {busy, m_tvalid}, 2'b00);
    if (busy) do_reset(2);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ty;
    rst_n = 1'b0; en = 1'b0; sha_type = 2'b00;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    do_reset(3);

    msg_str("abc");
    build(2'b01);
    run(2'b01, 0, 0, 0, 512'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, "abc256");
    build(2'b00);
    run(2'b00, 0, 2, 0, 512'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, "abc224");
    build(2'b11);
    run(2'b11, 0, 0, 0,
        512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f,
        "abc512");
    build(2'b10);
    run(2'b10, 10, 3, 1,
        512'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7,
        "abc384");

    msg_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    build(2'b01);
    run(2'b01, 30, 20, 0, 512'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, "two256");

    // Abort a SHA-256 block after 30 rounds; nothing may come out for it.
    msg_str("abc");
    build(2'b01);
    @(negedge clk);
    sha_type = 2'b01;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      s_tvalid = 1'b1;
      s_tdata = wq[i];
      s_tlast = 1'b0;
      @(negedge clk);
    end
    do_reset(3);
    repeat (10) begin
      @(negedge clk);
      check("abort_quiet", {busy, m_tvalid}, 2'b00);
    end
    run(2'b01, 0, 0, 0, 512'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, "after_rst");

    repeat (6) begin
      ty = 2'($urandom_range(3));
      msg_rand($urandom_range(0, 250));
      build(ty);
      run(ty, $urandom_range(0, 40), $urandom_range(0, 5), 1'($urandom_range(1)), mdl_dig, "rand");
    end

    @(negedge clk);
    check("digest_count", 512'(dig_cnt), 512'(runs));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
